axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- N:1 AXI4 read-channel interconnect. NUM_SLAVE upstream AXI4 read masters share one downstream AXI4 read slave.
- AR requests are arbitrated round-robin and registered. The upstream port index is appended above the ID on the downstream side, so R beats route back by RID with no lookup table.
- Outstanding reads are bounded by a counter.
- This is the read half of the next-generation multi-port crossbar.

Parameters:
AXI_ID_WIDTH, 1, upstream ID width
AXI_DATA_WIDTH, 32, data width
AXI_ADDR_WIDTH, 8, address width
NUM_SLAVE, 2, upstream port count (2..16)
MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts (1..255)
(derived) SEL_W = max(1, clog2(NUM_SLAVE)); MID_W = AXI_ID_WIDTH+SEL_W

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
S_AXI_ARID  in  NUM_SLAVE*AXI_ID_WIDTH  per-port ID, port 0 in LSBs (same packing for all S_ vectors)
S_AXI_ARADDR  in  NUM_SLAVE*AXI_ADDR_WIDTH  address
S_AXI_ARLEN  in  NUM_SLAVE*8  burst length-1
S_AXI_ARSIZE  in  NUM_SLAVE*3  beat size
S_AXI_ARBURST  in  NUM_SLAVE*2  burst type
S_AXI_ARVALID  in  NUM_SLAVE  request valid
S_AXI_ARREADY  out  NUM_SLAVE  request accepted
S_AXI_RID  out  NUM_SLAVE*AXI_ID_WIDTH  returned ID (lower bits of M_AXI_RID)
S_AXI_RDATA  out  NUM_SLAVE*AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  NUM_SLAVE*2  response
S_AXI_RLAST  out  NUM_SLAVE  last beat
S_AXI_RVALID  out  NUM_SLAVE  beat valid
S_AXI_RREADY  in  NUM_SLAVE  beat ready
M_AXI_ARID  out  MID_W  {port index, upstream ID}
M_AXI_ARADDR  out  AXI_ADDR_WIDTH  address
M_AXI_ARLEN  out  8  burst length-1
M_AXI_ARSIZE  out  3  beat size
M_AXI_ARBURST  out  2  burst type
M_AXI_ARVALID  out  1  request valid
M_AXI_ARREADY  in  1  request ready
M_AXI_RID  in  MID_W  returned extended ID
M_AXI_RDATA  in  AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  response
M_AXI_RLAST  in  1  last beat
M_AXI_RVALID  in  1  beat valid
M_AXI_RREADY  out  1  beat ready

Behaviour:
- Reset (async, ARESET=1): all M_AXI_AR* registers 0, M_AXI_ARVALID=0, S_AXI_ARREADY=0, RR pointer=0, outstanding count=0, state=IDLE.
- AR FSM IDLE:
  - Arbitration is enabled when any S_AXI_ARVALID is set and count<MAX_OUTSTANDING.
  - The winner is the first requesting port at or after the pointer, wrapping.
  - S_AXI_ARREADY[winner]=1 that cycle, combinational from registered state plus ARVALID. At most one ARREADY bit is set.
  - On that edge: latch payload, set M_AXI_ARID={winner, ARID}, set M_AXI_ARVALID=1, pointer=winner+1 mod NUM_SLAVE, go to BUSY.
- AR FSM BUSY:
  - Payload and M_AXI_ARVALID stay stable. All S_AXI_ARREADY=0.
  - On M_AXI_ARREADY=1: count+1, M_AXI_ARVALID=0, go to IDLE.
  - Throughput is one AR per 2 cycles minimum. Latency is 1 cycle from upstream accept to M_AXI_ARVALID.
- Outstanding counter:
  - Decrements on an M R handshake with RLAST=1.
  - An increment and a decrement in the same cycle leave the count unchanged.
  - At count==MAX_OUTSTANDING, IDLE grants nothing and the pointer is held.
  - The counter never overflows or underflows. An R-last handshake at count==0 is ignored, and an assertion fires in simulation.
- R path (combinational, zero latency):
  - idx = M_AXI_RID[MID_W-1:AXI_ID_WIDTH].
  - S_AXI_RVALID[idx]=M_AXI_RVALID; all other RVALID bits are 0.
  - M_AXI_RREADY=S_AXI_RREADY[idx].
  - RDATA, RRESP, RLAST and the lower RID bits are broadcast to all ports.
  - If idx>=NUM_SLAVE: M_AXI_RREADY=1 and the beat is dropped with no S valid, but the count still decrements on RLAST.
- Interleaved R beats from different ports are permitted and routed per beat.
- A port whose ARVALID drops while not granted loses no state; the pointer only moves on a grant.

Test Plan:
- Reset mid-BUSY (ARESET pulse) -> next cycle M_AXI_ARVALID=0, count=0, pointer=0; with port1 requesting after release, grant goes to port1 as the first requester at or after the pointer.
- NUM_SLAVE=2, both ARVALID held, M_AXI_ARREADY=1 -> grants alternate 0,1,0,1. M_AXI_ARID upper bit follows the grant, and M_AXI_ARVALID rises 1 cycle after each S_AXI_ARREADY pulse.
- Port1 ARID=1 ADDR=0x40 LEN=3, M_AXI_ARREADY low 5 cycles -> M payload stable throughout and no further S_AXI_ARREADY until the handshake.
- MAX_OUTSTANDING=2, 3 requests, no R -> 2 accepted, third ARREADY stays 0. One RLAST handshake on port0 -> third accepted next IDLE cycle.
- R beats with RID={1,0} then {0,1} interleaved, RREADY[1]=0 -> only port1 RVALID is set, M_AXI_RREADY=0 during the stall, and the port0 beat is delivered with S_AXI_RID=1.
- NUM_SLAVE=3, M_AXI_RID index 3 with RLAST -> M_AXI_RREADY=1, no S RVALID, count decremented.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - N:1 AXI4 read-channel arbiter, round-robin AR, RID-routed R
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AR*             NUM_SLAVE upstream AR channels, port 0 in the LSBs
//   S_AXI_R*              NUM_SLAVE upstream R channels (data/resp/last/id broadcast)
//   M_AXI_AR*             registered downstream AR channel, ARID = {port, upstream ID}
//   M_AXI_R*              downstream R channel, routed by the upper RID bits
module axi_rd_arbiter #(
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 8,
  parameter int NUM_SLAVE       = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SEL_W = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1,
  localparam int MID_W = AXI_ID_WIDTH + SEL_W
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [NUM_SLAVE*AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [NUM_SLAVE*AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [NUM_SLAVE*8-1:0]              S_AXI_ARLEN,
  input  logic [NUM_SLAVE*3-1:0]              S_AXI_ARSIZE,
  input  logic [NUM_SLAVE*2-1:0]              S_AXI_ARBURST,
  input  logic [NUM_SLAVE-1:0]                S_AXI_ARVALID,
  output logic [NUM_SLAVE-1:0]                S_AXI_ARREADY,
  output logic [NUM_SLAVE*AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [NUM_SLAVE*AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [NUM_SLAVE*2-1:0]              S_AXI_RRESP,
  output logic [NUM_SLAVE-1:0]                S_AXI_RLAST,
  output logic [NUM_SLAVE-1:0]                S_AXI_RVALID,
  input  logic [NUM_SLAVE-1:0]                S_AXI_RREADY,
  output logic [MID_W-1:0]                    M_AXI_ARID,
  output logic [AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [7:0]                          M_AXI_ARLEN,
  output logic [2:0]                          M_AXI_ARSIZE,
  output logic [1:0]                          M_AXI_ARBURST,
  output logic                                M_AXI_ARVALID,
  input  logic                                M_AXI_ARREADY,
  input  logic [MID_W-1:0]                    M_AXI_RID,
  input  logic [AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                          M_AXI_RRESP,
  input  logic                                M_AXI_RLAST,
  input  logic                                M_AXI_RVALID,
  output logic                                M_AXI_RREADY
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   count;

  logic               grant_valid;
  logic [SEL_W-1:0]   winner;
  logic               arb_en;
  logic               ar_take;
  logic               ar_inc;
  logic               r_last_hs;
  logic               r_dec;

  logic [AXI_ID_WIDTH-1:0]   win_id;
  logic [AXI_ADDR_WIDTH-1:0] win_addr;
  logic [7:0]                win_len;
  logic [2:0]                win_size;
  logic [1:0]                win_burst;

  logic [SEL_W-1:0]   r_idx;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin : arbitrate
    int cand;
    grant_valid = 1'b0;
    winner      = '0;
    cand        = 0;
    for (int k = 0; k < NUM_SLAVE; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_SLAVE) cand = cand - NUM_SLAVE;
      if (!grant_valid && S_AXI_ARVALID[cand]) begin
        grant_valid = 1'b1;
        winner      = SEL_W'(cand);
      end
    end
  end

  // Payload of the winning port, selected with constant part-selects.
  always_comb begin
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    win_size  = '0;
    win_burst = '0;
    for (int p = 0; p < NUM_SLAVE; p++) begin
      if (winner == SEL_W'(p)) begin
        win_id    = S_AXI_ARID[p*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        win_addr  = S_AXI_ARADDR[p*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        win_len   = S_AXI_ARLEN[p*8 +: 8];
        win_size  = S_AXI_ARSIZE[p*3 +: 3];
        win_burst = S_AXI_ARBURST[p*2 +: 2];
      end
    end
  end

  // Reset is folded in so no upstream port sees a grant while reset is held.
  assign arb_en  = (state == IDLE) && (count < CNT_W'(MAX_OUTSTANDING)) && !ARESET;
  assign ar_take = arb_en && grant_valid;
  assign S_AXI_ARREADY = ar_take ? (NUM_SLAVE'(1) << winner) : '0;

  assign ar_inc    = (state == BUSY) && M_AXI_ARREADY;
  assign r_last_hs = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;
  // A last beat with nothing outstanding is a downstream protocol error; drop it.
  assign r_dec     = r_last_hs && (count != '0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      count         <= '0;
      M_AXI_ARID    <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARSIZE  <= '0;
      M_AXI_ARBURST <= '0;
      M_AXI_ARVALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_take) begin
            M_AXI_ARID    <= {winner, win_id};
            M_AXI_ARADDR  <= win_addr;
            M_AXI_ARLEN   <= win_len;
            M_AXI_ARSIZE  <= win_size;
            M_AXI_ARBURST <= win_burst;
            M_AXI_ARVALID <= 1'b1;
            rr_ptr        <= (winner == SEL_W'(NUM_SLAVE - 1)) ? '0 : winner + SEL_W'(1);
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Simultaneous accept and completion cancel out.
      if (ar_inc && !r_dec)
        count <= count + CNT_W'(1);
      else if (!ar_inc && r_dec)
        count <= count - CNT_W'(1);
    end
  end

  always @(posedge ACLK) begin
    if (!ARESET) begin
      a_no_underflow: assert (!(r_last_hs && (count == '0)));
    end
  end

  // R path: the port index rides in the upper RID bits, so routing is a pure decode.
  assign r_idx = M_AXI_RID[MID_W-1:AXI_ID_WIDTH];

  // An index with no matching port is sunk here (RREADY stays 1, no S valid).
  always_comb begin
    S_AXI_RVALID = '0;
    M_AXI_RREADY = 1'b1;
    for (int p = 0; p < NUM_SLAVE; p++) begin
      if (r_idx == SEL_W'(p)) begin
        S_AXI_RVALID[p] = M_AXI_RVALID;
        M_AXI_RREADY    = S_AXI_RREADY[p];
      end
    end
  end

  assign S_AXI_RID   = {NUM_SLAVE{M_AXI_RID[AXI_ID_WIDTH-1:0]}};
  assign S_AXI_RDATA = {NUM_SLAVE{M_AXI_RDATA}};
  assign S_AXI_RRESP = {NUM_SLAVE{M_AXI_RRESP}};
  assign S_AXI_RLAST = {NUM_SLAVE{M_AXI_RLAST}};

endmodule
